// File: rtl/demux_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 8;

  typedef enum logic {
    BUSCA,
    RECEBE
  } state_t;

  typedef logic [$clog2(DEF_N)-1:0] chan_t;

endpackage

// File: rtl/demux_tdm.sv
// TDM byte demultiplexer: rebuilds N parallel channels from a sync-marked serial byte stream.
// Optional even-parity checking per beat is enabled with DEMUX_PARITY_EN.
module demux_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          Entrada,
  input  logic                      Valido,
  input  logic                      Sinc,
  input  logic                      Limpa_erro,
`ifdef DEMUX_PARITY_EN
  input  logic                      Paridade,
`endif
  output logic [N-1:0][WIDTH-1:0]   Saida,
  output logic [$clog2(N)-1:0]      Sinal,
  output logic                      Quadro_ok,
  output logic                      Erro
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [N-1:0][WIDTH-1:0]   shadow;
  logic                      bad;
  logic                      par_ok;
  logic                      err_set;
  logic [N-1:0][WIDTH-1:0]   merged;

`ifdef DEMUX_PARITY_EN
  assign par_ok = ~(^{Entrada, Paridade});
`else
  assign par_ok = 1'b1;
`endif

  assign Sinal = cnt;

  // Final byte is merged combinationally so the commit happens on the same edge.
  always_comb begin
    merged         = shadow;
    merged[N-1]    = Entrada;
  end

  always_comb begin
    err_set = 1'b0;
    if (Valido) begin
      case (state)
        BUSCA:  err_set = Sinc & ~par_ok;
        RECEBE: err_set = ~par_ok | (Sinc & (cnt != '0)) | (~Sinc & (cnt == '0));
        default: err_set = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BUSCA;
      cnt       <= '0;
      shadow    <= '0;
      bad       <= 1'b0;
      Saida     <= '0;
      Quadro_ok <= 1'b0;
      Erro      <= 1'b0;
    end else begin
      Quadro_ok <= 1'b0;
      Erro      <= err_set | (Erro & ~Limpa_erro);
      if (Valido) begin
        case (state)
          BUSCA: begin
            if (Sinc && par_ok) begin
              shadow[0] <= Entrada;
              cnt       <= CW'(1);
              bad       <= 1'b0;
              state     <= RECEBE;
            end
          end
          RECEBE: begin
            if (Sinc) begin
              // Sync always restarts the frame; an early one drops the partial frame.
              shadow[0] <= Entrada;
              cnt       <= CW'(1);
              bad       <= ~par_ok;
            end else if (cnt == '0) begin
              state <= BUSCA;
            end else begin
              shadow[cnt] <= Entrada;
              bad         <= bad | ~par_ok;
              if (cnt == LAST) begin
                cnt <= '0;
                if (!bad && par_ok) begin
                  Saida     <= merged;
                  Quadro_ok <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= BUSCA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_tdm.sv
// Self-checking bench for demux_tdm: queue-based frame model plus directed literal checks.
module tb_demux_tdm;

  localparam int W = 8;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [W-1:0]      Entrada = '0;
  logic              Valido = 1'b0;
  logic              Sinc = 1'b0;
  logic              Limpa_erro = 1'b0;
`ifdef DEMUX_PARITY_EN
  logic              Paridade = 1'b0;
`endif
  logic [N-1:0][W-1:0] Saida;
  logic [2:0]        Sinal;
  logic              Quadro_ok;
  logic              Erro;

  int n_chk  = 0;
  int n_fail = 0;

  demux_tdm #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .Entrada(Entrada), .Valido(Valido), .Sinc(Sinc),
    .Limpa_erro(Limpa_erro),
`ifdef DEMUX_PARITY_EN
    .Paridade(Paridade),
`endif
    .Saida(Saida), .Sinal(Sinal), .Quadro_ok(Quadro_ok), .Erro(Erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes gathered since the last sync; a frame exists once N are collected.
  logic [W-1:0]        q[$];
  bit                  hunting = 1'b1;
  bit                  fbad = 1'b0;
  bit                  m_valid = 1'b0;
  logic [N-1:0][W-1:0] m_saida = '0;
  bit                  m_qok = 1'b0;
  bit                  m_err = 1'b0;

  task automatic model_step();
    bit e;
    bit pb;
    e  = 1'b0;
    pb = 1'b0;
`ifdef DEMUX_PARITY_EN
    pb = ^{Entrada, Paridade};
`endif
    if (rst) begin
      q.delete(); hunting = 1'b1; fbad = 1'b0;
      m_saida = '0; m_qok = 1'b0; m_err = 1'b0;
      return;
    end
    m_qok = 1'b0;
    if (Valido) begin
      if (Sinc) begin
        if (hunting) begin
          if (pb) e = 1'b1;
          else begin q.delete(); q.push_back(Entrada); hunting = 1'b0; fbad = 1'b0; end
        end else begin
          if (q.size() != 0) e = 1'b1;
          q.delete(); q.push_back(Entrada);
          fbad = pb;
          if (pb) e = 1'b1;
        end
      end else if (!hunting) begin
        if (q.size() == 0) begin
          e = 1'b1; hunting = 1'b1;
        end else begin
          q.push_back(Entrada);
          if (pb) begin fbad = 1'b1; e = 1'b1; end
          if (q.size() == N) begin
            if (!fbad) begin
              for (int i = 0; i < N; i++) m_saida[i] = q[i];
              m_qok = 1'b1;
            end
            q.delete();
          end
        end
      end
    end
    m_err = e | (m_err & ~Limpa_erro);
  endtask

  // Compare at the falling edge, then advance the model with the inputs the next rising edge samples.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("m_saida", Saida, m_saida);
      chk("m_sinal", {61'd0, Sinal}, 64'(q.size()));
      chk("m_qok", {63'd0, Quadro_ok}, {63'd0, m_qok});
      chk("m_erro", {63'd0, Erro}, {63'd0, m_err});
    end
    model_step();
    m_valid = 1'b1;
  end

  logic [W-1:0] f1[8] = '{8'h00, 8'h02, 8'h02, 8'h07, 8'h04, 8'h08, 8'h0F, 8'h40};
  logic [W-1:0] f2[8] = '{8'h11, 8'h23, 8'h35, 8'h47, 8'h59, 8'h6B, 8'h7D, 8'h8F};

  function automatic logic [63:0] pack(input logic [W-1:0] a[8]);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = a[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input bit s, input bit corrupt);
    Entrada = d; Sinc = s; Valido = 1'b1;
`ifdef DEMUX_PARITY_EN
    Paridade = (^d) ^ corrupt;
`else
    if (corrupt) Entrada = d;
`endif
    tick();
    Valido = 1'b0; Sinc = 1'b0;
  endtask

  task automatic idle(input int n);
    Valido = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [W-1:0] a[8], input int gap_at, input int bad_at);
    for (int i = 0; i < 8; i++) begin
      beat(a[i], i == 0, i == bad_at);
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          chk("gap_sinal", {61'd0, Sinal}, 64'd4);
        end
      end
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_saida", Saida, 64'd0);
    chk("rst_sinal", {61'd0, Sinal}, 64'd0);
    chk("rst_qok", {63'd0, Quadro_ok}, 64'd0);
    chk("rst_erro", {63'd0, Erro}, 64'd0);
    rst = 1'b0;

    // Back-to-back frame
    send_frame(f1, -1, -1);
    chk("f1_qok", {63'd0, Quadro_ok}, 64'd1);
    chk("f1_ch5", {56'd0, Saida[5]}, 64'h08);
    chk("f1_ch7", {56'd0, Saida[7]}, 64'h40);
    chk("f1_sinal", {61'd0, Sinal}, 64'd0);
    chk("f1_erro", {63'd0, Erro}, 64'd0);
    idle(1);
    chk("f1_qok_pulse", {63'd0, Quadro_ok}, 64'd0);

    // Same frame with a mid-frame gap
    send_frame(f1, 3, -1);
    chk("gap_qok", {63'd0, Quadro_ok}, 64'd1);
    chk("gap_saida", Saida, 64'h400F080407020200);
    idle(2);

    // Stray bytes while hunting
    rst = 1'b1; tick(); rst = 1'b0;
    beat(8'h55, 1'b0, 1'b0);
    beat(8'h66, 1'b0, 1'b0);
    chk("hunt_saida", Saida, 64'd0);
    chk("hunt_sinal", {61'd0, Sinal}, 64'd0);
    chk("hunt_erro", {63'd0, Erro}, 64'd0);
    send_frame(f1, -1, -1);
    chk("hunt_commit", Saida, pack(f1));

    // Early sync on the fifth beat
    for (int i = 0; i < 4; i++) beat(f2[i], i == 0, 1'b0);
    beat(f2[0], 1'b1, 1'b0);
    chk("early_erro", {63'd0, Erro}, 64'd1);
    chk("early_saida", Saida, pack(f1));
    chk("early_sinal", {61'd0, Sinal}, 64'd1);
    for (int i = 1; i < 8; i++) beat(f2[i], 1'b0, 1'b0);
    chk("early_commit", Saida, pack(f2));
    chk("early_qok", {63'd0, Quadro_ok}, 64'd1);
    Limpa_erro = 1'b1; tick(); Limpa_erro = 1'b0;
    chk("clear_erro", {63'd0, Erro}, 64'd0);

    // Reset mid-frame, with a valid beat held during reset
    for (int i = 0; i < 4; i++) beat(f2[i], i == 0, 1'b0);
    rst = 1'b1;
    beat(f2[4], 1'b0, 1'b0);
    rst = 1'b0;
    chk("mrst_saida", Saida, 64'd0);
    chk("mrst_sinal", {61'd0, Sinal}, 64'd0);
    send_frame(f1, -1, -1);
    chk("mrst_commit", Saida, pack(f1));

    // Lost sync: non-sync beat where channel 0 is expected
    beat(8'h99, 1'b0, 1'b0);
    chk("lost_erro", {63'd0, Erro}, 64'd1);
    chk("lost_sinal", {61'd0, Sinal}, 64'd0);
    beat(8'h98, 1'b0, 1'b0);
    Limpa_erro = 1'b1; tick(); Limpa_erro = 1'b0;
    send_frame(f2, -1, -1);
    chk("lost_commit", Saida, pack(f2));

`ifdef DEMUX_PARITY_EN
    idle(1);
    send_frame(f1, -1, 2);
    chk("par_qok", {63'd0, Quadro_ok}, 64'd0);
    chk("par_saida", Saida, pack(f2));
    chk("par_erro", {63'd0, Erro}, 64'd1);
    Limpa_erro = 1'b1; tick(); Limpa_erro = 1'b0;
    send_frame(f1, -1, -1);
    chk("par_commit", Saida, pack(f1));
    chk("par_clean_erro", {63'd0, Erro}, 64'd0);
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
